// File: rtl/audioport_pkg.sv
// Shared audio-port types and default sizing for the mclk-domain sample FIFO.
package audioport_pkg;

  localparam int unsigned FIFO_CHANNELS = 2;
  localparam int unsigned FIFO_WIDTH    = 24;
  localparam int unsigned FIFO_DEPTH    = 8;
  localparam int unsigned FIFO_LOW_MARK = 2;

  typedef logic [FIFO_CHANNELS-1:0][FIFO_WIDTH-1:0] sample_frame_t;

  typedef enum logic {
    FIFO_IDLE = 1'b0,
    FIFO_PLAY = 1'b1
  } fifo_state_t;

endpackage

// File: rtl/sample_fifo_mem.sv
// Frame storage: DEPTH frames, one synchronous write port, one combinational read port.
module sample_fifo_mem #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                              clk_i,
  input  logic                              we_i,
  input  logic [$clog2(DEPTH)-1:0]          waddr_i,
  input  logic [CHANNELS-1:0][WIDTH-1:0]    wdata_i,
  input  logic [$clog2(DEPTH)-1:0]          raddr_i,
  output logic [CHANNELS-1:0][WIDTH-1:0]    rdata_o
);

  // Contents are meaningless until written; the level counter guards every read.
  logic [CHANNELS-1:0][WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mclk_sample_fifo.sv
// DEPTH-frame audio sample FIFO with flush on stop, mono duplication,
// low-watermark refill request and sticky overflow/underflow flags.
module mclk_sample_fifo
  import audioport_pkg::*;
#(
  parameter int unsigned CHANNELS = FIFO_CHANNELS,
  parameter int unsigned WIDTH    = FIFO_WIDTH,
  parameter int unsigned DEPTH    = FIFO_DEPTH,
  parameter int unsigned LOW_MARK = FIFO_LOW_MARK
) (
  input  logic                              mclk,
  input  logic                              mrst,
  input  logic                              tick_in,
  input  logic [CHANNELS-1:0][WIDTH-1:0]    dsp_in,
  input  logic                              play_in,
  input  logic                              mono_in,
  input  logic                              clr_flags_in,
  input  logic                              req_in,
  output logic [CHANNELS-1:0][WIDTH-1:0]    dsp_out,
  output logic                              valid_out,
  output logic                              refill_out,
  output logic [$clog2(DEPTH+1)-1:0]        level_out,
  output logic                              ovf_out,
  output logic                              udf_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LOW  = LW'(LOW_MARK);

  fifo_state_t                     state_q, state_d;
  logic [AW-1:0]                   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]                   level_q, level_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  dsp_q, dsp_d, rd_frame;
  logic                            valid_q, valid_d;
  logic                            ovf_q, ovf_d, udf_q, udf_d;
  logic                            wr_en, rd_en;

  sample_fifo_mem #(
    .CHANNELS(CHANNELS),
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH)
  ) u_mem (
    .clk_i  (mclk),
    .we_i   (wr_en),
    .waddr_i(wptr_q),
    .wdata_i(dsp_in),
    .raddr_i(rptr_q),
    .rdata_o(rd_frame)
  );

  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      state_q <= FIFO_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      dsp_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      dsp_q   <= dsp_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_comb begin
    state_d = play_in ? FIFO_PLAY : FIFO_IDLE;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    dsp_d   = dsp_q;
    valid_d = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    // Clear first so a same-cycle set below wins.
    ovf_d   = ovf_q & ~clr_flags_in;
    udf_d   = udf_q & ~clr_flags_in;

    unique case (state_d)
      FIFO_IDLE: begin
        wptr_d  = '0;
        rptr_d  = '0;
        level_d = '0;
        dsp_d   = '0;
      end
      FIFO_PLAY: begin
        rd_en = req_in && (level_q != '0);
        // A read in the same cycle frees the slot a full FIFO would otherwise lack.
        wr_en = tick_in && ((level_q != FULL) || req_in);
        if (tick_in && (level_q == FULL) && !req_in) begin
          ovf_d = 1'b1;
        end
        if (req_in) begin
          valid_d = 1'b1;
          if (rd_en) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
              dsp_d[c] = mono_in ? rd_frame[0] : rd_frame[c];
            end
          end else begin
            dsp_d = '0;
            udf_d = 1'b1;
          end
        end
        if (wr_en) wptr_d = wptr_q + 1'b1;
        if (rd_en) rptr_d = rptr_q + 1'b1;
        level_d = level_q + LW'(wr_en) - LW'(rd_en);
      end
      default: ;
    endcase
  end

  assign dsp_out    = dsp_q;
  assign valid_out  = valid_q;
  assign level_out  = level_q;
  assign ovf_out    = ovf_q;
  assign udf_out    = udf_q;
  assign refill_out = (state_q == FIFO_PLAY) && (level_q <= LOW);

endmodule

// File: tb/tb_mclk_sample_fifo.sv
// Self-checking bench for mclk_sample_fifo: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_mclk_sample_fifo;
  import audioport_pkg::*;

  localparam int CH = 2;
  localparam int W  = 24;
  localparam int D  = 8;
  localparam int LM = 2;
  localparam int FW = CH * W;

  logic          mclk = 1'b0;
  logic          mrst;
  logic          tick_in, play_in, mono_in, clr_flags_in, req_in;
  logic [FW-1:0] dsp_in, dsp_out;
  logic          valid_out, refill_out, ovf_out, udf_out;
  logic [3:0]    level_out;

  mclk_sample_fifo #(
    .CHANNELS(CH),
    .WIDTH   (W),
    .DEPTH   (D),
    .LOW_MARK(LM)
  ) dut (
    .mclk        (mclk),
    .mrst        (mrst),
    .tick_in     (tick_in),
    .dsp_in      (dsp_in),
    .play_in     (play_in),
    .mono_in     (mono_in),
    .clr_flags_in(clr_flags_in),
    .req_in      (req_in),
    .dsp_out     (dsp_out),
    .valid_out   (valid_out),
    .refill_out  (refill_out),
    .level_out   (level_out),
    .ovf_out     (ovf_out),
    .udf_out     (udf_out)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int errors = 0;

  // Reference model: the FIFO contents as a plain queue of frames.
  logic [FW-1:0] mq[$];
  logic [FW-1:0] m_dsp;
  logic          m_valid, m_ovf, m_udf, m_play;

  function automatic logic [FW-1:0] fr(input logic [23:0] c0, input logic [23:0] c1);
    return {c1, c0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dsp = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_play = 1'b0;
  endtask

  task automatic model_step();
    logic          full;
    logic [FW-1:0] f;
    m_play = play_in;
    m_valid = 1'b0;
    if (clr_flags_in) begin m_ovf = 1'b0; m_udf = 1'b0; end
    if (!play_in) begin
      mq.delete();
      m_dsp = '0;
    end else begin
      full = (mq.size() == D);
      if (req_in) begin
        m_valid = 1'b1;
        if (mq.size() > 0) begin
          f = mq.pop_front();
          m_dsp = mono_in ? {f[23:0], f[23:0]} : f;
        end else begin
          m_dsp = '0;
          m_udf = 1'b1;
        end
      end
      if (tick_in) begin
        if (!full || req_in) mq.push_back(dsp_in);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    chk("model_dsp",    64'(dsp_out),    64'(m_dsp));
    chk("model_valid",  64'(valid_out),  64'(m_valid));
    chk("model_level",  64'(level_out),  64'(mq.size()));
    chk("model_refill", 64'(refill_out), 64'(m_play && (mq.size() <= LM)));
    chk("model_ovf",    64'(ovf_out),    64'(m_ovf));
    chk("model_udf",    64'(udf_out),    64'(m_udf));
  endtask

  task automatic cyc(input logic t, input logic r, input logic p, input logic m,
                     input logic c, input logic [FW-1:0] d);
    tick_in = t; req_in = r; play_in = p; mono_in = m; clr_flags_in = c; dsp_in = d;
    @(posedge mclk);
    model_step();
    #1;
    check_model();
  endtask

  typedef struct {
    logic          tick, req, play, mono, clr;
    logic [FW-1:0] din;
    int            lvl;
    logic          vld;
    logic [FW-1:0] dsp;
    logic          ovf, udf, rf;
  } vec_t;

  function automatic vec_t mk(input logic t, input logic r, input logic m, input logic c,
                              input logic [FW-1:0] d, input int l, input logic v,
                              input logic [FW-1:0] o, input logic ov, input logic ud,
                              input logic rf);
    vec_t x;
    x.tick = t; x.req = r; x.play = 1'b1; x.mono = m; x.clr = c; x.din = d;
    x.lvl = l; x.vld = v; x.dsp = o; x.ovf = ov; x.udf = ud; x.rf = rf;
    return x;
  endfunction

  vec_t tbl[14];

  initial begin
    logic [FW-1:0] hold;
    mrst = 1'b1;
    tick_in = 0; req_in = 0; play_in = 0; mono_in = 0; clr_flags_in = 0; dsp_in = '0;
    model_reset();
    #12;
    chk("rst_dsp",    64'(dsp_out),    0);
    chk("rst_valid",  64'(valid_out),  0);
    chk("rst_level",  64'(level_out),  0);
    chk("rst_refill", 64'(refill_out), 0);
    chk("rst_ovf",    64'(ovf_out),    0);
    chk("rst_udf",    64'(udf_out),    0);
    mrst = 1'b0;
    @(posedge mclk); #1;

    //              t  r  m  c  din                       lvl v  dsp                      ov ud rf
    tbl[0]  = mk(0, 0, 0, 0, '0,                        0, 0, '0,                        0, 0, 1);
    tbl[1]  = mk(1, 0, 0, 0, fr(24'h000001, 24'h800001), 1, 0, '0,                        0, 0, 1);
    tbl[2]  = mk(1, 0, 0, 0, fr(24'h000002, 24'h800002), 2, 0, '0,                        0, 0, 1);
    tbl[3]  = mk(1, 0, 0, 0, fr(24'h000003, 24'h800003), 3, 0, '0,                        0, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, '0,                        2, 1, fr(24'h000001, 24'h800001), 0, 0, 1);
    tbl[5]  = mk(0, 1, 0, 0, '0,                        1, 1, fr(24'h000002, 24'h800002), 0, 0, 1);
    tbl[6]  = mk(0, 1, 0, 0, '0,                        0, 1, fr(24'h000003, 24'h800003), 0, 0, 1);
    tbl[7]  = mk(0, 0, 0, 0, '0,                        0, 0, fr(24'h000003, 24'h800003), 0, 0, 1);
    tbl[8]  = mk(0, 1, 0, 0, '0,                        0, 1, '0,                        0, 1, 1);
    tbl[9]  = mk(1, 1, 0, 0, fr(24'h0000AA, 24'h0000BB), 1, 1, '0,                        0, 1, 1);
    tbl[10] = mk(0, 1, 0, 0, '0,                        0, 1, fr(24'h0000AA, 24'h0000BB), 0, 1, 1);
    tbl[11] = mk(0, 0, 0, 1, '0,                        0, 0, fr(24'h0000AA, 24'h0000BB), 0, 0, 1);
    tbl[12] = mk(1, 0, 0, 0, fr(24'h123456, 24'hABCDEF), 1, 0, fr(24'h0000AA, 24'h0000BB), 0, 0, 1);
    tbl[13] = mk(0, 1, 1, 0, '0,                        0, 1, fr(24'h123456, 24'h123456), 0, 0, 1);

    foreach (tbl[i]) begin
      cyc(tbl[i].tick, tbl[i].req, tbl[i].play, tbl[i].mono, tbl[i].clr, tbl[i].din);
      chk($sformatf("tbl%0d_level", i),  64'(level_out),  64'(tbl[i].lvl));
      chk($sformatf("tbl%0d_valid", i),  64'(valid_out),  64'(tbl[i].vld));
      chk($sformatf("tbl%0d_dsp", i),    64'(dsp_out),    64'(tbl[i].dsp));
      chk($sformatf("tbl%0d_ovf", i),    64'(ovf_out),    64'(tbl[i].ovf));
      chk($sformatf("tbl%0d_udf", i),    64'(udf_out),    64'(tbl[i].udf));
      chk($sformatf("tbl%0d_refill", i), 64'(refill_out), 64'(tbl[i].rf));
    end

    // Overflow: fill, one extra tick dropped, clear, then tick+req at full.
    for (int i = 0; i < D; i++) cyc(1, 0, 1, 0, 0, fr(24'h100 + 24'(i), 24'h200 + 24'(i)));
    chk("full_level", 64'(level_out), D);
    chk("full_refill", 64'(refill_out), 0);
    cyc(1, 0, 1, 0, 0, fr(24'hBAD, 24'hBAD));
    chk("ovf_level", 64'(level_out), D);
    chk("ovf_set", 64'(ovf_out), 1);
    cyc(0, 0, 1, 0, 1, '0);
    chk("ovf_clr", 64'(ovf_out), 0);
    cyc(1, 1, 1, 0, 0, fr(24'h300, 24'h300));
    chk("fullrw_level", 64'(level_out), D);
    chk("fullrw_ovf", 64'(ovf_out), 0);
    chk("fullrw_dsp", 64'(dsp_out), 64'(fr(24'h100, 24'h200)));
    for (int i = 1; i < D; i++) begin
      cyc(0, 1, 1, 0, 0, '0);
      chk("drain_dsp", 64'(dsp_out), 64'(fr(24'h100 + 24'(i), 24'h200 + 24'(i))));
    end
    cyc(0, 1, 1, 0, 0, '0);
    chk("drain_last", 64'(dsp_out), 64'(fr(24'h300, 24'h300)));
    chk("drain_empty", 64'(level_out), 0);

    // Flush: flags survive a stop, contents do not.
    cyc(0, 1, 1, 0, 0, '0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 0, fr(24'h40 + 24'(i), 24'h50));
    cyc(0, 1, 1, 0, 0, '0);
    chk("pre_flush_dsp", 64'(dsp_out), 64'(fr(24'h40, 24'h50)));
    cyc(1, 1, 0, 0, 0, fr(24'h77, 24'h77));
    chk("flush_level", 64'(level_out), 0);
    chk("flush_dsp", 64'(dsp_out), 0);
    chk("flush_valid", 64'(valid_out), 0);
    chk("flush_refill", 64'(refill_out), 0);
    chk("flush_udf", 64'(udf_out), 1);
    cyc(0, 0, 1, 0, 0, '0);
    chk("replay_level", 64'(level_out), 0);
    chk("replay_refill", 64'(refill_out), 1);
    chk("replay_udf", 64'(udf_out), 1);

    // Asynchronous reset in the middle of a read cycle.
    cyc(1, 0, 1, 0, 0, fr(24'hABC, 24'hDEF));
    cyc(1, 0, 1, 0, 0, fr(24'h111, 24'h222));
    cyc(0, 1, 1, 0, 0, '0);
    hold = dsp_out;
    chk("mid_read_dsp", 64'(hold), 64'(fr(24'hABC, 24'hDEF)));
    #2 mrst = 1'b1;
    model_reset();
    #1;
    chk("arst_dsp",    64'(dsp_out),    0);
    chk("arst_valid",  64'(valid_out),  0);
    chk("arst_level",  64'(level_out),  0);
    chk("arst_refill", 64'(refill_out), 0);
    chk("arst_udf",    64'(udf_out),    0);
    #3 mrst = 1'b0;
    @(posedge mclk); #1;

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 19) != 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 15) == 0), {$urandom(), $urandom()} & {FW{1'b1}});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
